// File: rtl/urv_pipe_ctrl_if.sv
// Pipeline-control bundle between the uRV stage instances (master) and urv_pipe_ctrl (slave).
// Carries stall/valid requests in and per-stage stall/kill, halt status and perf counters out.
interface urv_pipe_ctrl_if #(
  parameter int g_num_stages = 4
);
  logic [g_num_stages-1:0] stall_req_i;
  logic [g_num_stages-1:0] valid_i;
  logic                    bra_i;
  logic                    flush_i;
  logic                    halt_req_i;
  logic                    resume_i;
  logic                    perf_clr_i;
  logic [g_num_stages-1:0] stall_o;
  logic [g_num_stages-1:0] kill_o;
  logic                    halted_o;
  logic [31:0]             perf_stall_cnt_o;
  logic [31:0]             perf_kill_cnt_o;

  modport master (
    output stall_req_i, valid_i, bra_i, flush_i, halt_req_i, resume_i, perf_clr_i,
    input  stall_o, kill_o, halted_o, perf_stall_cnt_o, perf_kill_cnt_o
  );

  modport slave (
    input  stall_req_i, valid_i, bra_i, flush_i, halt_req_i, resume_i, perf_clr_i,
    output stall_o, kill_o, halted_o, perf_stall_cnt_o, perf_kill_cnt_o
  );
endinterface

// File: rtl/urv_pipe_ctrl.sv
// uRV pipeline control: stall aggregation, branch kill shadow, debug halt/drain, flush; URV_PIPE_PERF_CNT_EN adds perf counters.
// stall_o/kill_o are combinational from inputs and state; halted_o and counters update one cycle after their cause.
module urv_pipe_ctrl #(
  parameter int         g_num_stages      = 4,
  parameter int         g_branch_stage    = 2,
  parameter logic [7:0] g_self_stall_mask = 8'b0000_1100
) (
  input  logic           clk_i,
  input  logic           rst_i,
  urv_pipe_ctrl_if.slave pipe
);
  localparam int N = g_num_stages;
  localparam int B = g_branch_stage;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t       state_q;
  logic         halted_q;
  logic [B-1:0] sr_q;
  logic [N-1:0] stall;
  logic [N-1:0] kill;
  logic         pipe_empty;
  logic         unused_valid0;

  // Fetch validity does not matter for draining: fetch is frozen outside RUN.
  assign unused_valid0 = pipe.valid_i[0];
  assign pipe_empty    = ~|pipe.valid_i[N-1:1] && ~|pipe.stall_req_i;

  always_comb begin
    stall = '0;
    for (int s = 0; s < N; s++) begin
      for (int k = s + 1; k < N; k++) begin
        stall[s] = stall[s] | pipe.stall_req_i[k];
      end
      stall[s] = stall[s] | (g_self_stall_mask[s] & pipe.stall_req_i[s]);
    end
    if (state_q != ST_RUN) begin
      stall[0] = 1'b1;
    end
  end

  always_comb begin
    kill = '0;
    for (int s = 1; s <= B; s++) begin
      kill[s] = pipe.bra_i;
      for (int i = 0; i < s; i++) begin
        kill[s] = kill[s] | sr_q[i];
      end
    end
    if (pipe.flush_i) begin
      kill[N-1:1] = '1;
    end
  end

  assign pipe.stall_o  = stall;
  assign pipe.kill_o   = kill;
  assign pipe.halted_o = halted_q;

  // The shadow only advances when the branch stage moves, so a stalled branch keeps its wake aligned.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else if (!stall[B]) begin
      sr_q[0] <= pipe.bra_i;
      for (int i = 1; i < B; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pipe.halt_req_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!pipe.halt_req_i) begin
            state_q <= ST_RUN;
          end else if (pipe_empty) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (pipe.resume_i) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef URV_PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q;
  logic [31:0] perf_kill_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_cnt_q <= '0;
      perf_kill_cnt_q  <= '0;
    end else if (pipe.perf_clr_i) begin
      perf_stall_cnt_q <= '0;
      perf_kill_cnt_q  <= '0;
    end else begin
      if (state_q == ST_RUN && stall[0]) begin
        perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
      end
      if (|kill) begin
        perf_kill_cnt_q <= perf_kill_cnt_q + 32'd1;
      end
    end
  end

  assign pipe.perf_stall_cnt_o = perf_stall_cnt_q;
  assign pipe.perf_kill_cnt_o  = perf_kill_cnt_q;
`else
  logic unused_perf_clr;

  assign unused_perf_clr       = pipe.perf_clr_i;
  assign pipe.perf_stall_cnt_o = 32'h0;
  assign pipe.perf_kill_cnt_o  = 32'h0;
`endif

endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Bench for urv_pipe_ctrl (N=4, B=2): directed vector table, perf-counter sequences, randomized run vs. reference model.
module tb_urv_pipe_ctrl;
  localparam int N = 4;
  localparam int B = 2;
  localparam logic [3:0] MASK = 4'b1100;
`ifdef URV_PIPE_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  urv_pipe_ctrl_if #(.g_num_stages(N)) pif ();

  urv_pipe_ctrl #(
    .g_num_stages     (N),
    .g_branch_stage   (B),
    .g_self_stall_mask(8'h0C)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .pipe (pif)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0=run, 1=drain, 2=halted; ages of taken branches in branch-stage advances.
  int          mode;
  int          ages[$];
  logic [31:0] m_scnt;
  logic [31:0] m_kcnt;

  typedef struct {
    logic [3:0] req;
    logic [3:0] valid;
    logic       bra;
    logic       flush;
    logic       halt;
    logic       resume;
    logic [3:0] e_stall;
    logic [3:0] e_kill;
    logic       e_halted;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] m_stall(input logic [3:0] req, input int md);
    logic [3:0] r;
    for (int s = 0; s < N; s++) begin
      r[s] = ((req >> (s + 1)) != 4'd0) || (MASK[s] && req[s]);
    end
    if (md != 0) r[0] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] m_kill(input logic bra, input logic flush);
    logic [3:0] r;
    r = 4'b0000;
    for (int s = 1; s <= B; s++) begin
      r[s] = bra;
      foreach (ages[j]) if (ages[j] <= s) r[s] = 1'b1;
    end
    if (flush) r = r | 4'b1110;
    return r;
  endfunction

  task automatic model_reset();
    mode = 0;
    ages.delete();
    m_scnt = '0;
    m_kcnt = '0;
  endtask

  task automatic model_update();
    logic [3:0] st;
    logic [3:0] kl;
    int         nxt[$];
    logic       empty;
    st = m_stall(pif.stall_req_i, mode);
    kl = m_kill(pif.bra_i, pif.flush_i);
    if (PERF_EN) begin
      if (pif.perf_clr_i) begin
        m_scnt = '0;
        m_kcnt = '0;
      end else begin
        if (mode == 0 && st[0]) m_scnt = m_scnt + 1;
        if (kl != 0) m_kcnt = m_kcnt + 1;
      end
    end
    if (!st[B]) begin
      foreach (ages[j]) if (ages[j] + 1 <= B) nxt.push_back(ages[j] + 1);
      if (pif.bra_i) nxt.push_back(1);
      ages = nxt;
    end
    empty = (pif.valid_i[3:1] == 3'b000) && (pif.stall_req_i == 4'b0000);
    case (mode)
      0: if (pif.halt_req_i) mode = 1;
      1: if (!pif.halt_req_i) mode = 0; else if (empty) mode = 2;
      default: if (pif.resume_i) mode = 0;
    endcase
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] valid, input logic bra,
                       input logic flush, input logic halt, input logic resume, input logic clr);
    pif.stall_req_i = req;
    pif.valid_i     = valid;
    pif.bra_i       = bra;
    pif.flush_i     = flush;
    pif.halt_req_i  = halt;
    pif.resume_i    = resume;
    pif.perf_clr_i  = clr;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic check_perf(input string tag);
    chk({tag, " perf_stall"}, pif.perf_stall_cnt_o, m_scnt);
    chk({tag, " perf_kill"}, pif.perf_kill_cnt_o, m_kcnt);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " stall"}, 32'(pif.stall_o), 32'(m_stall(pif.stall_req_i, mode)));
    chk({tag, " kill"}, 32'(pif.kill_o), 32'(m_kill(pif.bra_i, pif.flush_i)));
    chk({tag, " halted"}, 32'(pif.halted_o), 32'(mode == 2));
    check_perf(tag);
  endtask

  task automatic add(input logic [3:0] req, input logic [3:0] valid, input logic bra, input logic flush,
                     input logic halt, input logic resume, input logic [3:0] es, input logic [3:0] ek,
                     input logic eh);
    vec_t v;
    v.req = req; v.valid = valid; v.bra = bra; v.flush = flush; v.halt = halt; v.resume = resume;
    v.e_stall = es; v.e_kill = ek; v.e_halted = eh;
    tbl.push_back(v);
  endtask

  initial begin
    //   req      valid    bra flush halt res  stall    kill     halted
    add(4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0110, 0);  // branch pulse, shadow 0110/0110/0100/0000
    add(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0110, 0);
    add(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0100, 0);
    add(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0110, 0);  // branch then writeback stall freezes shadow
    add(4'b1000, 4'b0000, 0, 0, 0, 0, 4'b1111, 4'b0110, 0);
    add(4'b1000, 4'b0000, 0, 0, 0, 0, 4'b1111, 4'b0110, 0);
    add(4'b1000, 4'b0000, 0, 0, 0, 0, 4'b1111, 4'b0110, 0);
    add(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0110, 0);
    add(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0100, 0);
    add(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0010, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b0000, 0);  // stall aggregation patterns
    add(4'b0100, 4'b0000, 0, 0, 0, 0, 4'b0111, 4'b0000, 0);
    add(4'b1000, 4'b0000, 0, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(4'b0001, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 4'b1110, 0, 0, 1, 0, 4'b0000, 4'b0000, 0);  // halt request, drain one stage per cycle
    add(4'b0000, 4'b1110, 0, 0, 1, 0, 4'b0001, 4'b0000, 0);
    add(4'b0000, 4'b1100, 0, 0, 1, 0, 4'b0001, 4'b0000, 0);
    add(4'b0000, 4'b1000, 0, 0, 1, 0, 4'b0001, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 0, 1, 0, 4'b0001, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 0, 1, 0, 4'b0001, 4'b0000, 1);
    add(4'b0000, 4'b0000, 0, 0, 0, 1, 4'b0001, 4'b0000, 1);
    add(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 4'b0110, 0, 0, 1, 0, 4'b0000, 4'b0000, 0);  // flush and branch inside DRAIN
    add(4'b0000, 4'b0110, 0, 1, 1, 0, 4'b0001, 4'b1110, 0);
    add(4'b0000, 4'b0110, 0, 0, 1, 0, 4'b0001, 4'b0000, 0);
    add(4'b0000, 4'b0110, 1, 1, 1, 0, 4'b0001, 4'b1110, 0);
    add(4'b0000, 4'b0110, 0, 0, 1, 0, 4'b0001, 4'b0110, 0);
    add(4'b0000, 4'b0110, 0, 0, 1, 0, 4'b0001, 4'b0100, 0);
    add(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b0000, 0);  // halt dropped in DRAIN
    add(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 0, 0, 1, 4'b0000, 4'b0000, 0);  // stray resume in RUN / DRAIN
    add(4'b0000, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 0, 1, 1, 4'b0001, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b0000, 1);
    add(4'b0000, 4'b0000, 0, 0, 0, 1, 4'b0001, 4'b0000, 1);
    add(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 1, 0, 0, 4'b0000, 4'b1110, 0);  // flush in RUN

    model_reset();
    drive(4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    chk("reset stall", 32'(pif.stall_o), 32'h0);
    chk("reset kill", 32'(pif.kill_o), 32'h0);
    chk("reset halted", 32'(pif.halted_o), 32'h0);
    chk("reset perf_stall", pif.perf_stall_cnt_o, 32'h0);
    chk("reset perf_kill", pif.perf_kill_cnt_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_model("post-reset");

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].valid, tbl[i].bra, tbl[i].flush, tbl[i].halt, tbl[i].resume, 1'b0);
      chk($sformatf("row%0d stall", i), 32'(pif.stall_o), 32'(tbl[i].e_stall));
      chk($sformatf("row%0d kill", i), 32'(pif.kill_o), 32'(tbl[i].e_kill));
      chk($sformatf("row%0d halted", i), 32'(pif.halted_o), 32'(tbl[i].e_halted));
      check_perf($sformatf("row%0d", i));
      advance();
    end

    // Five stalled RUN cycles, then clear.
    drive(4'b0000, 4'b0000, 0, 0, 0, 0, 1);
    advance();
    for (int c = 0; c < 5; c++) begin
      drive(4'b0010, 4'b0000, 0, 0, 0, 0, 0);
      advance();
    end
    drive(4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    chk("perf five stalls", pif.perf_stall_cnt_o, PERF_EN ? 32'd5 : 32'd0);
    check_perf("perf five stalls model");
    drive(4'b0010, 4'b0000, 1, 0, 0, 0, 1);
    advance();
    drive(4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    chk("perf clear stall", pif.perf_stall_cnt_o, 32'd0);
    chk("perf clear kill", pif.perf_kill_cnt_o, 32'd0);
    advance();

`ifdef URV_PIPE_PERF_CNT_EN
    force dut.perf_stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_stall_cnt_q;
    m_scnt = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      drive(4'b0010, 4'b0000, 0, 0, 0, 0, 0);
      advance();
    end
    drive(4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    chk("perf wrap", pif.perf_stall_cnt_o, 32'h0000_0001);
    advance();
`endif

    // Randomized run against the reference model, from a fresh reset.
    rst = 1'b1;
    model_reset();
    #1;
    rst = 1'b0;
    @(negedge clk);
    begin
      logic       halt;
      logic [3:0] req;
      halt = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(15) == 0) halt = ~halt;
        for (int b = 0; b < N; b++) req[b] = ($urandom_range(5) == 0);
        drive(req, 4'($urandom), $urandom_range(3) == 0, $urandom_range(15) == 0, halt,
              $urandom_range(5) == 0, $urandom_range(63) == 0);
        check_model($sformatf("rand%0d", c));
        advance();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
